// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the two-port data-bus arbiter.
// Purely declarative: no logic, no latency.
// Backpressure is not applicable here; see data_bus_arbiter.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        read_enable;
    logic        write_enable;
  } bus_req_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Bundle of both requester ports plus the shared memory bus.
// The slave modport is the arbiter's view; master is the environment's view.
// Requesters hold their inputs until ack; the bus stalls via bus_ready.
interface data_bus_arbiter_if;
  logic [31:0] m0_address;
  logic [31:0] m0_write_data;
  logic [3:0]  m0_byte_enable;
  logic        m0_read_enable;
  logic        m0_write_enable;
  logic [31:0] m0_read_data;
  logic        m0_ack;
  logic        m0_error;

  logic [31:0] m1_address;
  logic [31:0] m1_write_data;
  logic [3:0]  m1_byte_enable;
  logic        m1_read_enable;
  logic        m1_write_enable;
  logic [31:0] m1_read_data;
  logic        m1_ack;
  logic        m1_error;

  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_read_data;
  logic        bus_ready;

  modport slave (
    input  m0_address, m0_write_data, m0_byte_enable, m0_read_enable, m0_write_enable,
    output m0_read_data, m0_ack, m0_error,
    input  m1_address, m1_write_data, m1_byte_enable, m1_read_enable, m1_write_enable,
    output m1_read_data, m1_ack, m1_error,
    output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    input  bus_read_data, bus_ready
  );

  modport master (
    output m0_address, m0_write_data, m0_byte_enable, m0_read_enable, m0_write_enable,
    input  m0_read_data, m0_ack, m0_error,
    output m1_address, m1_write_data, m1_byte_enable, m1_read_enable, m1_write_enable,
    input  m1_read_data, m1_ack, m1_error,
    input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    output bus_read_data, bus_ready
  );
endinterface

// File: rtl/data_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie, the port that did not win last time wins.
// Combinational, zero latency.
// No backpressure; the caller decides when a grant is taken.
module rr_arbiter2
  import data_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  // Pick a single requester, alternating on ties.
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = PORT_CORE;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_grant_i;
    end else if (req_i[1]) begin
      gnt_idx_o = PORT_AUX;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one memory bus between the core (port 0) and an aux master (port 1), one access in flight.
// Latency: grant in IDLE, bus driven next cycle, ack one cycle after bus_ready (3 cycles minimum).
// Requests wait while BUSY/RESP; memory stalls via bus_ready. Optional ARBITER_TIMEOUT_EN aborts hung accesses.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  data_bus_arbiter_if.slave   bus
);

  arb_state_t  state_q, state_d;
  bus_req_t    req_q, req_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  req_vec;
  logic        gnt_vld, gnt_idx;
  bus_req_t    req0, req1;

`ifdef ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  assign req_vec = {bus.m1_read_enable | bus.m1_write_enable,
                    bus.m0_read_enable | bus.m0_write_enable};

  // A request with both strobes set is carried as a pure write.
  assign req0 = '{address:      bus.m0_address,
                  write_data:   bus.m0_write_data,
                  byte_enable:  bus.m0_byte_enable,
                  read_enable:  bus.m0_read_enable & ~bus.m0_write_enable,
                  write_enable: bus.m0_write_enable};
  assign req1 = '{address:      bus.m1_address,
                  write_data:   bus.m1_write_data,
                  byte_enable:  bus.m1_byte_enable,
                  read_enable:  bus.m1_read_enable & ~bus.m1_write_enable,
                  write_enable: bus.m1_write_enable};

  rr_arbiter2 u_rr (
    .req_i        (req_vec),
    .last_grant_i (last_grant_q),
    .gnt_vld_o    (gnt_vld),
    .gnt_idx_o    (gnt_idx)
  );

  // State, request and response registers; reset drops any in-flight access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      req_q        <= '0;
      last_grant_q <= PORT_AUX;
      gnt_q        <= PORT_CORE;
      rdata_q      <= '0;
`ifdef ARBITER_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      rdata_q      <= rdata_d;
`ifdef ARBITER_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // Next-state and outputs; outputs depend only on registered state so reset clears them at once.
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    last_grant_d     = last_grant_q;
    gnt_d            = gnt_q;
    rdata_d          = rdata_q;
    bus.bus_address      = '0;
    bus.bus_write_data   = '0;
    bus.bus_byte_enable  = '0;
    bus.bus_read_enable  = 1'b0;
    bus.bus_write_enable = 1'b0;
    bus.m0_read_data = '0;
    bus.m0_ack       = 1'b0;
    bus.m0_error     = 1'b0;
    bus.m1_read_data = '0;
    bus.m1_ack       = 1'b0;
    bus.m1_error     = 1'b0;
`ifdef ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
    cnt_inc = cnt_q + 1'b1;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (gnt_vld) begin
          req_d        = (gnt_idx == PORT_AUX) ? req1 : req0;
          gnt_d        = gnt_idx;
          last_grant_d = gnt_idx;
          rdata_d      = '0;
          state_d      = ARB_BUSY;
`ifdef ARBITER_TIMEOUT_EN
          cnt_d = '0;
          err_d = 1'b0;
`endif
        end
      end

      ARB_BUSY: begin
        bus.bus_address      = req_q.address;
        bus.bus_write_data   = req_q.write_data;
        bus.bus_byte_enable  = req_q.byte_enable;
        bus.bus_read_enable  = req_q.read_enable;
        bus.bus_write_enable = req_q.write_enable;
        if (bus.bus_ready) begin
          rdata_d = req_q.read_enable ? bus.bus_read_data : '0;
          state_d = ARB_RESP;
        end
`ifdef ARBITER_TIMEOUT_EN
        else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end

      ARB_RESP: begin
        if (gnt_q == PORT_AUX) begin
          bus.m1_ack       = 1'b1;
          bus.m1_read_data = rdata_q;
`ifdef ARBITER_TIMEOUT_EN
          bus.m1_error     = err_q;
`endif
        end else begin
          bus.m0_ack       = 1'b1;
          bus.m0_read_data = rdata_q;
`ifdef ARBITER_TIMEOUT_EN
          bus.m0_error     = err_q;
`endif
        end
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-port arbiter that shares one data-memory bus between the core's data-memory interface (port 0) and an auxiliary master such as a debug loader or DMA (port 1). It sits between the core's bus outputs and the memory/peripheral bus, and adds a ready handshake so memory can take several cycles. It uses round-robin arbitration, allows one outstanding transaction, and registers the request and response.

## Interface
- TIMEOUT_CYCLES, default 64: bus cycles allowed per transaction before abort. Used only with the timeout feature.
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- mX_address  in  32  port X address, X = 0, 1
- mX_write_data  in  32  port X store data
- mX_byte_enable  in  4  port X byte lanes
- mX_read_enable  in  1  port X read request
- mX_write_enable  in  1  port X write request
- mX_read_data  out  32  port X load data, valid while mX_ack = 1
- mX_ack  out  1  one-cycle pulse: port X transaction complete
- mX_error  out  1  one-cycle pulse with mX_ack when the transaction timed out (timeout build only, else tied 0)
- bus_address / bus_write_data / bus_byte_enable  out  32/32/4  shared bus
- bus_read_enable / bus_write_enable  out  1  shared bus strobes
- bus_read_data  in  32  shared bus load data
- bus_ready  in  1  memory completes the current access this cycle

## Operation
- Request: port X requests when mX_read_enable | mX_write_enable. The requester holds all mX_* inputs stable until it sees mX_ack. It may change them in the cycle after mX_ack.
- Both enables set: the access is performed as a write, and mX_read_data = 0 at ack.
- FSM states:
  - IDLE:
    - If no request, stay in IDLE.
    - If only one port requests, grant it.
    - If both request, grant the port not in last_grant.
    - On grant: latch that port's address, data, byte enables and strobes into the request register, update last_grant, and go to BUSY.
  - BUSY:
    - Drive the bus from the request register.
    - On bus_ready: latch bus_read_data (read) or 0 (write) and go to RESP.
  - RESP:
    - Pulse mX_ack for the granted port; mX_read_data shows the latched data.
    - Bus strobes are 0.
    - Go to IDLE.
- Bus outputs are all zero in IDLE and RESP. Only the granted port's mX_read_data is non-zero, and only in RESP.
- last_grant resets to 1, so port 0 wins the first tie.
- Arbitration is never pre-emptive: a granted transaction always runs to RESP.

## Timing
- Reset: state = IDLE, request register = 0, last_grant = 1. All outputs are 0 immediately (asynchronously).
- Reset mid-transaction: the transaction is dropped and no ack is produced. The requester re-issues after reset.
- Latency: request seen in IDLE at cycle N → bus driven from N+1 → bus_ready at cycle M ≥ N+1 → mX_ack at M+1.
- Minimum is 3 cycles per transaction with zero-wait memory (bus_ready high in the first BUSY cycle).
- Back-to-back: a requester that re-asserts immediately after ack is arbitrated in the following IDLE cycle. With both ports requesting continuously, grants strictly alternate.
- bus_ready outside BUSY is ignored.
- A request appearing while another transaction is in flight waits; it is never lost, since requests are level-held.
- mX_ack is never asserted on both ports in the same cycle.

## Configuration
- ARBITER_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without bus_ready.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to RESP with mX_read_data = 0 and pulses mX_error together with mX_ack.
  - bus_ready in the same cycle the limit is reached takes precedence: normal completion, no error.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- ARBITER_TIMEOUT_EN undefined: no counter exists, mX_error is tied to 0, and BUSY waits indefinitely.

## Structure
- Shared package holds:
  - the state enum (ARB_IDLE, ARB_BUSY, ARB_RESP)
  - a packed bus-request struct {address, write_data, byte_enable, read_enable, write_enable}
  - the port-index constants PORT_CORE = 0 and PORT_AUX = 1
- One sub-module is natural: rr_arbiter2. It is combinational and computes the grant from req[1:0] and last_grant, so the grant policy can be unit-tested on its own.
- The request register, response register and FSM live in data_bus_arbiter.

## Test plan
- Port 0 reads 0x0000_0100, memory returns 0xDEAD_BEEF with bus_ready in the first BUSY cycle → m0_ack at cycle 3 with m0_read_data = 0xDEAD_BEEF; port 1 outputs stay 0.
- Both ports write simultaneously out of reset (m0 to 0x10 with data 0x11, m1 to 0x20 with data 0x22) → bus shows the 0x10 write first, then 0x20; the acks alternate with no overlap.
- Both ports request continuously for 6 transactions → grant order is 0,1,0,1,0,1.
- bus_ready held low for 5 BUSY cycles on a port 1 read → bus signals stay stable throughout; m1_ack arrives exactly 1 cycle after bus_ready.
- reset asserted during BUSY → all outputs 0 in the same cycle; after release, port 0 wins the next tie and no stale ack appears.
- ARBITER_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and bus_ready never asserted → m0_ack and m0_error pulse together after 4 BUSY cycles, with m0_read_data = 0.
